// File: rtl/intercal_unselect.sv
// Bit-serial inverse of the INTERCAL select/mingle operators: deposit (inverse select)
// and unmingle, resolving BITS_PER_CYCLE result bits per cycle behind a valid/ready handshake.
module intercal_unselect #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  s,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] f,
    output logic        err,
    output logic        busy
);
    localparam int N  = 32 / BITS_PER_CYCLE;
    localparam int CW = $clog2(N);

    localparam logic [1:0] OP_DEP32 = 2'd0;
    localparam logic [1:0] OP_DEP16 = 2'd1;
    localparam logic [1:0] OP_UNM   = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      op;
    logic [31:0]     src, mask, res, res_nxt;
    logic [5:0]      ptr, ptr_nxt;
    logic [CW-1:0]   cnt;
    logic            err_q;
    logic            accept, last;
    logic [4:0]      bit_i, idx;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    // Bits of one cycle are resolved in ascending order so the source pointer
    // chains through them exactly as it would one bit per cycle.
    always_comb begin
        res_nxt = res;
        ptr_nxt = ptr;
        bit_i   = '0;
        idx     = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            bit_i = 5'(int'(cnt) * BITS_PER_CYCLE + k);
            case (op)
                OP_DEP32, OP_DEP16: begin
                    if (op == OP_DEP16 && bit_i == 5'd16) ptr_nxt = '0;
                    idx = (op == OP_DEP16 && bit_i[4]) ? {1'b1, ptr_nxt[3:0]} : ptr_nxt[4:0];
                    if (mask[bit_i]) begin
                        res_nxt[bit_i] = src[idx];
                        ptr_nxt        = ptr_nxt + 6'd1;
                    end else begin
                        res_nxt[bit_i] = 1'b0;
                    end
                end
                OP_UNM:  res_nxt[{bit_i[0], bit_i[4:1]}] = src[bit_i];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op    <= '0;
            src   <= '0;
            mask  <= '0;
            res   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op    <= s;
                    src   <= a;
                    mask  <= b;
                    res   <= '0;
                    ptr   <= '0;
                    cnt   <= '0;
                    err_q <= (s == 2'd3);
                end
                RUN: begin
                    res <= res_nxt;
                    ptr <= ptr_nxt;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign f   = res;
    assign err = err_q;
endmodule

// File: tb/tb_intercal_unselect.sv
// Directed + random checks of intercal_unselect at BITS_PER_CYCLE 1 and 4 side by side,
// against a reference model written from the operator definitions.
module tb_intercal_unselect;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  s = '0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready1, out_valid1, err1, busy1;
    logic        in_ready4, out_valid4, err4, busy4;
    logic [31:0] f1, f4;
    int          total = 0, bad = 0;

    intercal_unselect #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .s(s), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .f(f1), .err(err1), .busy(busy1));

    intercal_unselect #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .s(s), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
        .f(f4), .err(err4), .busy(busy4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scatter successive source bits into the set positions of the mask.
    function automatic logic [31:0] dep(input logic [31:0] src, input logic [31:0] m);
        logic [31:0] r = '0;
        int p = 0;
        for (int i = 0; i < 32; i++)
            if (m[i]) begin
                r[i] = src[p];
                p++;
            end
        return r;
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] m);
        logic [31:0] lo, hi, r;
        r = '0;
        case (op)
            2'd0: r = dep(x, m);
            2'd1: begin
                lo = dep({16'h0, x[15:0]},  {16'h0, m[15:0]});
                hi = dep({16'h0, x[31:16]}, {16'h0, m[31:16]});
                r  = {hi[15:0], lo[15:0]};
            end
            2'd2: for (int j = 0; j < 16; j++) begin
                r[16 + j] = x[2*j + 1];
                r[j]      = x[2*j];
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Present a request and leave the bench at the first negedge after the accept edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] m, input string tag);
        @(negedge clk);
        s = op; a = x; b = m; in_valid = 1'b1;
        chk({tag, "/in_ready"}, {30'd0, in_ready1, in_ready4}, 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        s = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input logic [31:0] expf, input logic experr, input string tag);
        int l1 = 0, l4 = 0;
        for (int c = 0; c <= 40; c++) begin
            if (out_valid4 && l4 == 0) l4 = c;
            if (out_valid1 && l1 == 0) l1 = c;
            if (out_valid1) break;
            @(negedge clk);
        end
        chk({tag, "/lat1"}, 32'(l1), 32'd32);
        chk({tag, "/lat4"}, 32'(l4), 32'd8);
        chk({tag, "/f1"}, f1, expf);
        chk({tag, "/f4"}, f4, expf);
        chk({tag, "/err"}, {30'd0, err1, err4}, {30'd0, experr, experr});
        chk({tag, "/rdy_busy"}, {28'd0, in_ready1, in_ready4, busy1, busy4}, 32'b0011);
    endtask

    task automatic release_op(input logic [31:0] expf, input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/idle"}, {26'd0, out_valid1, out_valid4, in_ready1, in_ready4, busy1, busy4}, 32'b001100);
        chk({tag, "/hold"}, f1, expf);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] m,
                         input logic [31:0] expf, input string tag);
        start_op(op, x, m, tag);
        wait_done(expf, op == 2'd3, tag);
        release_op(expf, tag);
    endtask

    initial begin
        logic [1:0]  rs;
        logic [31:0] ra, rb;
        #1;
        chk("reset/f", f1 | f4, 32'h0);
        chk("reset/flags", {22'd0, in_ready1, in_ready4, out_valid1, out_valid4,
            busy1, busy4, err1, err4, 2'b00}, 32'b1100000000);
        #20 rst_n = 1'b1;

        do_op(2'd0, 32'h000000A5, 32'hF0F00000, 32'hA0500000, "dep32");
        do_op(2'd1, 32'h00030001, 32'h80000100, 32'h80000100, "dep16a");
        do_op(2'd1, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFF, "dep16b");
        do_op(2'd2, 32'hAAAAAAAA, 32'h0, 32'hFFFF0000, "unm_aa");
        do_op(2'd2, 32'h00000001, 32'h0, 32'h00000001, "unm_1");
        do_op(2'd2, 32'h00000002, 32'h0, 32'h00010000, "unm_2");
        do_op(2'd3, 32'h12345678, 32'h9ABCDEF0, 32'h0, "rsvd");

        // Back-pressure: a waiting request must not slip in while DONE is held.
        start_op(2'd0, 32'h0000FFFF, 32'h00FF00FF, "bp");
        wait_done(32'h00FF00FF, 1'b0, "bp");
        s = 2'd2; a = 32'h55555555; b = 32'h0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp/stall", {29'd0, in_ready1, out_valid1, out_valid4}, 32'b011);
            chk("bp/f", f1, 32'h00FF00FF);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp/idle", {28'd0, out_valid1, in_ready1, in_ready4, busy1}, 32'b0110);
        @(negedge clk);
        chk("bp/accept", {30'd0, busy1, in_ready1}, 32'b10);
        in_valid = 1'b0;
        a = $urandom;
        wait_done(32'h0000FFFF, 1'b0, "bp2");
        release_op(32'h0000FFFF, "bp2");

        // Reset in the middle of RUN aborts the operation.
        start_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "rst");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst/flags", {28'd0, out_valid1, out_valid4, in_ready1, busy1}, 32'b0010);
        chk("rst/f", f1 | f4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'd0, 32'h00000001, 32'h80000000, 32'h80000000, "post_rst");

        for (int n = 0; n < 24; n++) begin
            rs = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (n % 3 == 0) ? ($urandom & $urandom) : $urandom;
            do_op(rs, ra, rb, model(rs, ra, rb), $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/intercal_unselect.md
Name: intercal_unselect

Overview:
- Iterative inverse-operator unit that reverses the INTERCAL select and mingle operators of the existing combinational ALU.
  - Deposit (inverse select): scatters packed low-order bits back to the positions marked by a mask.
  - Unmingle: de-interleaves a mingled word into its two 16-bit source operands.
- Sits beside the ALU on the same operand buses.
- Uses a valid/ready request/response handshake and a fixed, bit-serial latency.

Parameters:
BITS_PER_CYCLE, 1, result bits resolved per RUN cycle; legal 1, 2, 4; RUN length N = 32/BITS_PER_CYCLE cycles.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
s  input  2  op: 0 deposit32, 1 deposit16, 2 unmingle, 3 reserved
a  input  32  packed source (deposit) / mingled word (unmingle)
b  input  32  mask (deposit); ignored for unmingle
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
f  output  32  result
err  output  1  reserved op flag, qualified by out_valid
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1, out_valid=0, busy=0, err=0, f=0; counter, pointer and captured operands cleared. Reset in RUN or DONE aborts the operation, and no result is produced.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture s, a and b into internal registers, clear f, pointer=0 and cnt=0, then go to RUN.
  - Inputs are not sampled after acceptance.
- RUN: in_ready=0, busy=1.
  - Each cycle resolves result bits i = cnt*BITS_PER_CYCLE .. +BITS_PER_CYCLE-1, in ascending order.
  - After the edge resolving bit 31, go to DONE. out_valid rises exactly N cycles after the accept edge.
- deposit32, for each bit i:
  - If b[i]=1: f[i]=a[ptr], then ptr++.
  - If b[i]=0: f[i]=0.
  - ptr is 6 bits and never exceeds 32.
  - Property: select32(f,b) == a masked to its low popcount(b) bits.
- deposit16: same rule, with the halves independent.
  - Bits 0-15 use mask b[15:0] and source a[15:0].
  - At i=16, ptr resets to 0; bits 16-31 use mask b[31:16] and source a[16+ptr].
- unmingle:
  - Odd bit i goes to f[16 + (i>>1)]; even bit i goes to f[i>>1].
  - So f[31:16] recovers the mingle a-operand and f[15:0] recovers the b-operand.
- s=3: runs the full N cycles, f=0, err=1.
- DONE:
  - out_valid=1; f and err are held stable; in_ready=0.
  - On out_ready, go to IDLE, with out_valid=0 and busy=0 on the next cycle.
  - f holds its last value in IDLE.
  - out_ready is ignored outside DONE.
- No overlap: a request presented while busy is not accepted, so in_valid may stay high.
- Earliest back-to-back acceptance is the cycle after the output handshake.
- Throughput: one operation per N+2 cycles.

Test Plan:
- deposit32, a=0x000000A5, b=0xF0F00000 -> f=0xA0500000, err=0; out_valid exactly 32 cycles after accept.
- deposit16, a=0x00030001, b=0x80000100 -> f=0x80000100; then a=0xFFFFFFFF, b=0x0000FFFF -> f=0x0000FFFF.
- unmingle, a=0xAAAAAAAA -> f=0xFFFF0000; a=0x00000001 -> f=0x00000001; a=0x00000002 -> f=0x00010000.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> f stable, in_ready=0, no second accept. Release -> IDLE, then the new request is accepted the following cycle.
- Reset pulse at RUN cycle 10 -> out_valid=0, f=0, in_ready=1 immediately. Next deposit32, a=0x1, b=0x80000000 -> f=0x80000000.
- s=3 -> f=0, err=1 after 32 cycles. With BITS_PER_CYCLE=4, repeat the first case -> same f, latency 8.
